gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Command-driven sequencer for an N-bit Gray-code counter. It accepts a burst command (start index, step count, direction) over a valid/ready handshake, then steps the counter one Gray code per enabled cycle. It reports busy, wrap and done status. It sits between a control master (test sequencer or pointer manager) and the Gray counter datapath, which it instantiates.

Parameters:
N, 4, counter width in bits; index range 0..2^N-1

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-low; sampled on posedge clk
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted
cmd_start  in  N  binary start index
cmd_len  in  N  number of steps to take after load (0..2^N-1)
cmd_dir  in  1  0 = count up, 1 = count down
en  in  1  step enable; low pauses a running burst
abort  in  1  terminate the running burst
gray_out  out  N  registered Gray code of the current index
busy  out  1  burst running (state RUN)
done  out  1  one-cycle pulse at normal burst completion
wrap  out  1  one-cycle pulse after an index wrap-around

Behaviour:
- Reset (rst==0 at posedge): state IDLE, internal binary index 0, remaining 0, dir 0. Outputs: gray_out=0, busy=0, done=0, wrap=0. cmd_ready is forced 0 combinationally while rst==0.
- States: IDLE, RUN, DONE. Outputs: busy = (state==RUN); done = (state==DONE); cmd_ready = (state==IDLE) && rst.
- IDLE: on the edge where cmd_valid && cmd_ready:
  - latch index<=cmd_start, gray_out<=bin2gray(cmd_start), remaining<=cmd_len, dir<=cmd_dir.
  - Next state is RUN if cmd_len!=0, otherwise DONE.
  - gray_out reflects the start value one cycle after accept.
- RUN, on each edge with en==1 and abort==0:
  - index<=index±1 mod 2^N per dir; gray_out updates on the same edge.
  - remaining<=remaining-1.
  - If remaining==1, next state is DONE.
- RUN with en==0: index, gray_out and remaining all hold; no step is counted.
- Step property: consecutive gray_out values within a burst differ in exactly one bit.
- wrap: registered. High for the one cycle following a step from 2^N-1 to 0 (up) or from 0 to 2^N-1 (down). Never asserted by a load.
- DONE: lasts exactly one cycle, then IDLE. gray_out holds the last value and keeps holding in IDLE until the next accept.
- abort:
  - Sampled only in RUN, and has priority over en.
  - Next state is IDLE; no step is taken, no done pulse is produced, gray_out holds.
  - Ignored in IDLE and DONE.
- Latency: accept at edge k; steps at edges k+1..k+cmd_len when en stays high; done is high for the cycle after edge k+cmd_len.
- Reset mid-burst: returns to reset values on the next posedge. Any pending done or wrap pulse is suppressed.
- A command held valid during RUN/DONE is not accepted and must be held by the master.

Decomposition:
- Shared package/include gray_ctrl_pkg holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - bin2gray function (b ^ (b>>1)).
- One sub-module, gray_counter_core, contains the datapath:
  - inputs: clk, rst, load, load_val, step, dir;
  - outputs: bin, gray, wrap.
- gray_seq_ctrl holds the FSM, the remaining counter and the handshake only.

Test Plan:
1. rst=0 for 2 cycles with cmd_valid=1 -> cmd_ready=0, gray_out=0000, busy=0, done=0, wrap=0; after rst=1 -> cmd_ready=1 in IDLE.
2. start=0, len=5, dir=0, en=1 -> gray_out 0000,0001,0011,0010,0110,0111 on successive cycles; done high one cycle with gray_out=0111; wrap never asserted; cmd_ready returns the cycle after.
3. start=14, len=3, dir=0 -> gray_out 1001,1000,0000,0001; wrap high exactly the cycle gray_out=0000; then done.
4. start=1, len=2, dir=1 -> gray_out 0001,0000,1000; wrap high with gray_out=1000; done follows.
5. start=0, len=3, en low for 2 cycles after the first step -> gray_out holds 0001 for those cycles; still exactly 3 steps, ending at 0010, then done.
6. start=0, len=10, abort after step 2 -> busy=0 next cycle, no done, gray_out holds 0011, cmd_ready=1. Then start=7, len=0 -> gray_out=0100 and done high the cycle after accept, no busy cycle.

Source files
------------

// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray-code sequencer: FSM state encoding and
// the binary-to-Gray conversion used by the counter datapath.
package gray_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for any practical counter width; callers cast down to N bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_core.sv
// Gray counter datapath: binary index register with load/step, a registered
// Gray image of the index, and a registered one-cycle wrap flag.
module gray_counter_core
  import gray_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         step,
  input  logic         dir,
  output logic [N-1:0] bin,
  output logic [N-1:0] gray,
  output logic         wrap
);

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;

  // Next index: load wins over step; wrap only flags a step across the end.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (step) begin
      if (!dir) begin
        bin_d  = bin_q + N'(1);
        wrap_d = (bin_q == '1);
      end else begin
        bin_d  = bin_q - N'(1);
        wrap_d = (bin_q == '0);
      end
    end
    gray_d = N'(bin2gray(32'(bin_d)));
  end

  // Index, Gray image and wrap flag all update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Burst sequencer for a Gray counter. Handshake: a command transfers on the
// posedge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE and
// out of reset, and a master must hold cmd_valid and the command fields
// stable until that transfer edge.
module gray_seq_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_start,
  input  logic [N-1:0] cmd_len,
  input  logic         cmd_dir,
  input  logic         en,
  input  logic         abort,
  output logic [N-1:0] gray_out,
  output logic         busy,
  output logic         done,
  output logic         wrap
);

  state_t       state_q, state_d;
  logic [N-1:0] remaining_q, remaining_d;
  logic         dir_q, dir_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         accept;
  logic         step;
  logic [N-1:0] bin_unused;

  assign cmd_ready = (state_q == IDLE) && rst;
  assign accept    = cmd_valid && cmd_ready;
  // Abort outranks enable, so an aborting cycle never steps.
  assign step      = (state_q == RUN) && en && !abort;

  // Next-state, remaining-count and registered status computation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          remaining_d = cmd_len;
          dir_d       = cmd_dir;
          state_d     = (cmd_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (en) begin
          remaining_d = remaining_q - N'(1);
          if (remaining_q == N'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // FSM, remaining counter and status flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  gray_counter_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (cmd_start),
    .step     (step),
    .dir      (dir_q),
    .bin      (bin_unused),
    .gray     (gray_out),
    .wrap     (wrap)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl: linear steps, immediate-assert checks.
module tb_gray_seq_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_start;
  logic [N-1:0] cmd_len;
  logic         cmd_dir;
  logic         en;
  logic         abort;
  logic [N-1:0] gray_out;
  logic         busy;
  logic         done;
  logic         wrap;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 clk = ~clk;

  gray_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .cmd_dir   (cmd_dir),
    .en        (en),
    .abort     (abort),
    .gray_out  (gray_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  // Advance one edge; inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] g, input logic b,
                              input logic d, input logic w, input logic r);
    check({tag, ".gray"},  32'(gray_out),  32'(g));
    check({tag, ".busy"},  32'(busy),      32'(b));
    check({tag, ".done"},  32'(done),      32'(d));
    check({tag, ".wrap"},  32'(wrap),      32'(w));
    check({tag, ".ready"}, 32'(cmd_ready), 32'(r));
  endtask

  // Offer a command and let the accept edge happen, then withdraw it.
  task automatic send_cmd(input logic [3:0] s, input logic [3:0] l, input logic dr);
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_len   = l;
    cmd_dir   = dr;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b1; cmd_start = 4'd9; cmd_len = 4'd3;
    cmd_dir = 1'b0; en = 1'b1; abort = 1'b0;
    @(negedge clk);

    // 1: reset holds everything low, ready masked even with valid high
    check("rst.ready_comb", 32'(cmd_ready), 32'd0);
    tick();
    tick();
    expect_cycle("rst", 4'b0000, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst.ready_release", 32'(cmd_ready), 32'd1);

    // 2: start=0 len=5 up
    send_cmd(4'd0, 4'd5, 1'b0);
    expect_cycle("b2.c0", 4'b0000, 1, 0, 0, 0);
    tick(); expect_cycle("b2.c1", 4'b0001, 1, 0, 0, 0);
    tick(); expect_cycle("b2.c2", 4'b0011, 1, 0, 0, 0);
    tick(); expect_cycle("b2.c3", 4'b0010, 1, 0, 0, 0);
    tick(); expect_cycle("b2.c4", 4'b0110, 1, 0, 0, 0);
    tick(); expect_cycle("b2.c5", 4'b0111, 0, 1, 0, 0);
    tick(); expect_cycle("b2.idle", 4'b0111, 0, 0, 0, 1);

    // 3: start=14 len=3 up, wraps 15->0
    send_cmd(4'd14, 4'd3, 1'b0);
    expect_cycle("b3.c0", 4'b1001, 1, 0, 0, 0);
    tick(); expect_cycle("b3.c1", 4'b1000, 1, 0, 0, 0);
    tick(); expect_cycle("b3.c2", 4'b0000, 1, 0, 1, 0);
    tick(); expect_cycle("b3.c3", 4'b0001, 0, 1, 0, 0);
    tick(); expect_cycle("b3.idle", 4'b0001, 0, 0, 0, 1);

    // 4: start=1 len=2 down, wraps 0->15 on last step
    send_cmd(4'd1, 4'd2, 1'b1);
    expect_cycle("b4.c0", 4'b0001, 1, 0, 0, 0);
    tick(); expect_cycle("b4.c1", 4'b0000, 1, 0, 0, 0);
    tick(); expect_cycle("b4.c2", 4'b1000, 0, 1, 1, 0);
    tick(); expect_cycle("b4.idle", 4'b1000, 0, 0, 0, 1);

    // 5: start=0 len=3 with a two-cycle enable pause after the first step
    send_cmd(4'd0, 4'd3, 1'b0);
    expect_cycle("b5.c0", 4'b0000, 1, 0, 0, 0);
    tick(); expect_cycle("b5.c1", 4'b0001, 1, 0, 0, 0);
    en = 1'b0;
    tick(); expect_cycle("b5.p1", 4'b0001, 1, 0, 0, 0);
    tick(); expect_cycle("b5.p2", 4'b0001, 1, 0, 0, 0);
    en = 1'b1;
    tick(); expect_cycle("b5.c2", 4'b0011, 1, 0, 0, 0);
    tick(); expect_cycle("b5.c3", 4'b0010, 0, 1, 0, 0);
    tick(); expect_cycle("b5.idle", 4'b0010, 0, 0, 0, 1);

    // 6: abort after two steps, then a zero-length command
    send_cmd(4'd0, 4'd10, 1'b0);
    expect_cycle("b6.c0", 4'b0000, 1, 0, 0, 0);
    tick(); expect_cycle("b6.c1", 4'b0001, 1, 0, 0, 0);
    tick(); expect_cycle("b6.c2", 4'b0011, 1, 0, 0, 0);
    abort = 1'b1;
    tick(); expect_cycle("b6.abort", 4'b0011, 0, 0, 0, 1);
    abort = 1'b0;
    tick(); expect_cycle("b6.hold", 4'b0011, 0, 0, 0, 1);
    send_cmd(4'd7, 4'd0, 1'b0);
    expect_cycle("b6.len0", 4'b0100, 0, 1, 0, 0);
    tick(); expect_cycle("b6.len0_idle", 4'b0100, 0, 0, 0, 1);

    // Reset in the middle of a burst clears a pending wrap
    send_cmd(4'd15, 4'd3, 1'b0);
    expect_cycle("b7.c0", 4'b1000, 1, 0, 0, 0);
    tick(); expect_cycle("b7.c1", 4'b0000, 1, 0, 1, 0);
    rst = 1'b0;
    tick(); expect_cycle("b7.rst", 4'b0000, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("b7.ready_after", 32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
